alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, controller state encoding and instruction layout for the ALU issue path.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;
    localparam logic [3:0] OP_XOR    = 4'b1010;
    localparam logic [3:0] OP_NOT    = 4'b1011;
    localparam logic [3:0] OP_SHL    = 4'b1101;
    localparam logic [3:0] OP_PASS   = 4'b0100;
    localparam logic [3:0] OP_PASS_B = 4'b0110;
    localparam logic [3:0] OP_ZERO   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] opsel;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, writeback port
// and an external load port; writeback wins when both target the same entry.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        raddr1,
    input  logic [3:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [3:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    logic [NREGS-1:0][DATA_W-1:0] mem;
    logic                         ld_take;

    assign ld_take = ld_en && !(wb_en && (wb_addr == ld_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            if (ld_take)
                mem[ld_addr] <= ld_data;
            if (wb_en)
                mem[wb_addr] <= wb_data;
        end
    end

    // Reads see pre-edge contents; writes land at the edge.
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state sequencer feeding an external combinational ALU and writing results back.
// Optional macro ALU_FLAGS_EN adds registered zero/negative flags of the written value.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              ld_en,
    input  logic [3:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opsel,
    input  logic [DATA_W-1:0] alu_res,
    output logic              done,
    output logic [3:0]        done_rd,
`ifdef ALU_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
`endif
    output logic [DATA_W-1:0] done_data
);

    state_t            state, state_nxt;
    instr_t            cur;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_opsel <= OP_ZERO;
            result    <= '0;
            done      <= 1'b0;
            done_rd   <= '0;
            done_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (instr_valid) cur <= instr_t'(instr);
                READ: begin
                    alu_a     <= rs1_data;
                    alu_b     <= rs2_data;
                    alu_opsel <= cur.opsel;
                end
                EXEC: result <= alu_res;
                // done/done_* update on the same edge as the register-file write.
                WB: begin
                    done      <= 1'b1;
                    done_rd   <= cur.rd;
                    done_data <= result;
                    alu_opsel <= OP_ZERO;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == WB) begin
            flag_z <= (result == '0);
            flag_n <= result[DATA_W-1];
        end
    end
`endif

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr1  (cur.rs1),
        .raddr2  (cur.rs2),
        .rdata1  (rs1_data),
        .rdata2  (rs2_data),
        .wb_en   (state == WB),
        .wb_addr (cur.rd),
        .wb_data (result),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the combinational ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_opsel;
    logic        done;
    logic [3:0]  done_rd;
    logic [31:0] done_data;
`ifdef ALU_FLAGS_EN
    logic        flag_z, flag_n;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 32'h0;
        case (alu_opsel)
            OP_ADD:    alu_res = alu_a + alu_b;
            OP_SUB:    alu_res = alu_a - alu_b;
            OP_AND:    alu_res = alu_a & alu_b;
            OP_OR:     alu_res = alu_a | alu_b;
            OP_XOR:    alu_res = alu_a ^ alu_b;
            OP_NOT:    alu_res = ~alu_a;
            OP_SHL:    alu_res = alu_a << 1;
            OP_PASS:   alu_res = alu_a;
            OP_PASS_B: alu_res = alu_b;
            default:   alu_res = 32'h0;
        endcase
    end

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opsel   (alu_opsel),
        .alu_res     (alu_res),
        .done        (done),
        .done_rd     (done_rd),
`ifdef ALU_FLAGS_EN
        .flag_z      (flag_z),
        .flag_n      (flag_n),
`endif
        .done_data   (done_data)
    );

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Issue one instruction; optionally pulse an external load in the cycle
    // ending at edge ld_at after the handshake (1 = READ, 3 = WB).
    task automatic exec(input logic [3:0] op, rd, rs1, rs2, input int ld_at,
                        input logic [3:0] la, input logic [31:0] ldd,
                        output int lat, output logic [3:0] drd, output logic [31:0] dd);
        int n;
        @(negedge clk);
        instr_valid = 1'b1; instr = {op, rd, rs1, rs2};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = -1; drd = 4'h0; dd = 32'h0; n = 1;
        while (lat < 0 && n <= 8) begin
            if (n == ld_at) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
            @(posedge clk); #1;
            ld_en = 1'b0;
            if (done) begin lat = n; drd = done_rd; dd = done_data; end
            n++;
        end
    endtask

    task automatic run(input logic [3:0] op, rd, rs1, rs2,
                       output int lat, output logic [3:0] drd, output logic [31:0] dd);
        exec(op, rd, rs1, rs2, 0, 4'h0, 32'h0, lat, drd, dd);
    endtask

    task automatic test_reset;
        int lat; logic [3:0] drd; logic [31:0] dd;
        checks += 6;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", instr_ready); end
        if (alu_opsel !== 4'hF) begin failures++; $display("FAIL reset_opsel got=%h want=f", alu_opsel); end
        if (alu_a !== 32'h0 || alu_b !== 32'h0) begin failures++; $display("FAIL reset_operands got=%h/%h want=0/0", alu_a, alu_b); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        if (done_rd !== 4'h0) begin failures++; $display("FAIL reset_done_rd got=%h want=0", done_rd); end
        if (done_data !== 32'h0) begin failures++; $display("FAIL reset_done_data got=%h want=0", done_data); end
        run(OP_PASS, 4'd0, 4'd15, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h0) begin failures++; $display("FAIL reset_rf_clear got=%h want=0", dd); end
    endtask

    task automatic test_add;
        int lat; logic [3:0] drd; logic [31:0] dd;
        load(4'd1, 32'd5);
        load(4'd2, 32'd3);
        run(OP_ADD, 4'd4, 4'd1, 4'd2, lat, drd, dd);
        checks += 3;
        if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d want=3", lat); end
        if (drd !== 4'd4) begin failures++; $display("FAIL add_done_rd got=%0d want=4", drd); end
        if (dd !== 32'd8) begin failures++; $display("FAIL add_done_data got=%h want=8", dd); end
        checks += 2;
        if (alu_opsel !== 4'hF) begin failures++; $display("FAIL add_idle_opsel got=%h want=f", alu_opsel); end
        @(posedge clk); #1;
        if (done !== 1'b0) begin failures++; $display("FAIL add_done_single got=%b want=0", done); end
        run(OP_PASS, 4'd8, 4'd4, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'd8) begin failures++; $display("FAIL add_rf4 got=%h want=8", dd); end
    endtask

    task automatic test_sub_wrap;
        int lat; logic [3:0] drd; logic [31:0] dd;
        load(4'd1, 32'd0);
        load(4'd2, 32'd1);
        run(OP_SUB, 4'd5, 4'd1, 4'd2, lat, drd, dd);
        checks += 2;
        if (drd !== 4'd5) begin failures++; $display("FAIL sub_done_rd got=%0d want=5", drd); end
        if (dd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap got=%h want=ffffffff", dd); end
`ifdef ALU_FLAGS_EN
        checks += 2;
        if (flag_n !== 1'b1) begin failures++; $display("FAIL sub_flag_n got=%b want=1", flag_n); end
        if (flag_z !== 1'b0) begin failures++; $display("FAIL sub_flag_z got=%b want=0", flag_z); end
`endif
    endtask

    task automatic test_shift_not_undef;
        int lat; logic [3:0] drd; logic [31:0] dd;
        load(4'd1, 32'h8000_0001);
        run(OP_SHL, 4'd6, 4'd1, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h0000_0002) begin failures++; $display("FAIL shl got=%h want=00000002", dd); end
        run(OP_NOT, 4'd7, 4'd1, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h7FFF_FFFE) begin failures++; $display("FAIL not got=%h want=7ffffffe", dd); end
        load(4'd5, 32'd123);
        run(4'b0001, 4'd5, 4'd5, 4'd5, lat, drd, dd);
        checks++;
        if (dd !== 32'h0 || lat !== 3) begin failures++; $display("FAIL undef_op got=%h lat=%0d want=0 lat=3", dd, lat); end
`ifdef ALU_FLAGS_EN
        checks++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin failures++; $display("FAIL undef_flags got=z%b n%b want=z1 n0", flag_z, flag_n); end
`endif
        run(OP_PASS, 4'd8, 4'd5, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h0) begin failures++; $display("FAIL undef_writeback got=%h want=0", dd); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] rdy_hist, done_hist;
        logic [31:0] d0, d1;
        logic [3:0]  r0, r1;
        int nacc, a0, a1, nd;
        load(4'd1, 32'd1);
        load(4'd2, 32'd2);
        rdy_hist = '0; done_hist = '0; nacc = 0; a0 = -1; a1 = -1; nd = 0;
        d0 = '0; d1 = '0; r0 = '0; r1 = '0;
        @(negedge clk);
        instr_valid = 1'b1; instr = {OP_ADD, 4'd3, 4'd1, 4'd2};
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (nacc == 1 && c == a0 + 1) instr = {OP_ADD, 4'd9, 4'd3, 4'd2};
            if (nacc == 2 && c == a1 + 1) instr_valid = 1'b0;
            rdy_hist[c]  = instr_ready;
            done_hist[c] = done;
            if (done) begin
                if (nd == 0) begin d0 = done_data; r0 = done_rd; end
                if (nd == 1) begin d1 = done_data; r1 = done_rd; end
                nd++;
            end
            if (instr_ready && instr_valid) begin
                if (nacc == 0) a0 = c;
                if (nacc == 1) a1 = c;
                nacc++;
            end
        end
        instr_valid = 1'b0;
        checks += 5;
        if (nacc !== 2 || a0 !== 0 || a1 !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d@%0d,%0d want=2@0,4", nacc, a0, a1); end
        if (rdy_hist !== 12'hF11) begin failures++; $display("FAIL b2b_ready_pattern got=%h want=f11", rdy_hist); end
        if (done_hist !== 12'h110) begin failures++; $display("FAIL b2b_done_pattern got=%h want=110", done_hist); end
        if (r0 !== 4'd3 || d0 !== 32'd3) begin failures++; $display("FAIL b2b_first got=r%0d/%h want=r3/3", r0, d0); end
        if (r1 !== 4'd9 || d1 !== 32'd5) begin failures++; $display("FAIL b2b_second got=r%0d/%h want=r9/5", r1, d1); end
    endtask

    task automatic test_load_collision;
        int lat; logic [3:0] drd; logic [31:0] dd;
        load(4'd1, 32'd10);
        load(4'd2, 32'd20);
        exec(OP_ADD, 4'd4, 4'd1, 4'd2, 3, 4'd4, 32'hDEAD, lat, drd, dd);
        checks++;
        if (dd !== 32'd30) begin failures++; $display("FAIL coll_same_done got=%h want=1e", dd); end
        run(OP_PASS, 4'd8, 4'd4, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'd30) begin failures++; $display("FAIL coll_same_wb_wins got=%h want=1e", dd); end
        exec(OP_ADD, 4'd4, 4'd1, 4'd2, 3, 4'd5, 32'hDEAD, lat, drd, dd);
        run(OP_PASS, 4'd8, 4'd5, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'hDEAD) begin failures++; $display("FAIL coll_diff_load got=%h want=dead", dd); end
        run(OP_PASS, 4'd8, 4'd4, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'd30) begin failures++; $display("FAIL coll_diff_wb got=%h want=1e", dd); end
        exec(OP_ADD, 4'd6, 4'd1, 4'd2, 1, 4'd1, 32'd100, lat, drd, dd);
        checks++;
        if (dd !== 32'd30) begin failures++; $display("FAIL read_load_old got=%h want=1e", dd); end
        run(OP_PASS, 4'd8, 4'd1, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'd100) begin failures++; $display("FAIL read_load_lands got=%h want=64", dd); end
    endtask

    task automatic test_reset_mid_exec;
        int lat; logic [3:0] drd; logic [31:0] dd;
        logic seen;
        load(4'd1, 32'd7);
        load(4'd2, 32'd7);
        @(negedge clk);
        instr_valid = 1'b1; instr = {OP_ADD, 4'd2, 4'd1, 4'd2};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (alu_opsel !== 4'hF) begin failures++; $display("FAIL rst_exec_opsel got=%h want=f", alu_opsel); end
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_exec_ready got=%b want=1", instr_ready); end
        if (alu_a !== 32'h0) begin failures++; $display("FAIL rst_exec_alu_a got=%h want=0", alu_a); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= done; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); seen |= done; end
        checks += 2;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_exec_no_done got=%b want=0", seen); end
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_exec_ready_after got=%b want=1", instr_ready); end
        run(OP_PASS, 4'd8, 4'd1, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h0) begin failures++; $display("FAIL rst_exec_rf1 got=%h want=0", dd); end
        run(OP_PASS, 4'd8, 4'd2, 4'd0, lat, drd, dd);
        checks++;
        if (dd !== 32'h0) begin failures++; $display("FAIL rst_exec_rf2 got=%h want=0", dd); end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0;
        ld_en = 1'b0; ld_addr = 4'h0; ld_data = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub_wrap;
        test_shift_not_undef;
        test_back_to_back;
        test_load_collision;
        test_reset_mid_exec;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
